// File: rtl/layered_color_mapper.sv
// Layered colour compositor: priority/transparency resolve, then per-layer palette lookup.
// Optional palette readback port pair is enabled by defining LAYERED_CM_READBACK_EN.
module layered_color_mapper #(
   parameter int                     NUM_LAYERS   = 4,
   parameter int                     IDX_W        = 4,
   parameter int                     BLINK_FRAMES = 8,
   parameter logic [NUM_LAYERS-1:0]  BLINK_MASK   = NUM_LAYERS'(4'b0100),
   parameter logic [23:0]            BG_COLOR     = 24'h000000,
   localparam int                    LW           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
   localparam int                    OLW          = $clog2(NUM_LAYERS) + 1
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        pix_valid,
   input  logic [9:0]                  DrawX,
   input  logic [9:0]                  DrawY,
   input  logic [NUM_LAYERS-1:0]       layer_active,
   input  logic [NUM_LAYERS*IDX_W-1:0] layer_index,
   input  logic                        frame_start,
   input  logic                        pal_we,
   input  logic [LW-1:0]               pal_layer,
   input  logic [IDX_W-1:0]            pal_addr,
   input  logic [23:0]                 pal_data,
`ifdef LAYERED_CM_READBACK_EN
   input  logic                        pal_re,
   output logic [23:0]                 pal_rdata,
`endif
   output logic [7:0]                  VGA_R,
   output logic [7:0]                  VGA_G,
   output logic [7:0]                  VGA_B,
   output logic                        out_valid,
   output logic [OLW-1:0]              out_layer
);

   // Valid semantics: a pixel enters when pix_valid=1 and leaves exactly two
   // cycles later with out_valid=1; there is no ready/backpressure path.

   localparam int DEPTH = 2 ** IDX_W;

   logic [23:0]      pal_mem [NUM_LAYERS][DEPTH];
   logic [7:0]       frame_cnt;
   logic             blink_phase;
   logic             pal_layer_ok;

   logic             hit;
   logic [LW-1:0]    sel;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] lidx;
   logic             blank;

   logic             s1_valid;
   logic             s1_hit;
   logic [LW-1:0]    s1_sel;
   logic [IDX_W-1:0] s1_idx;
   logic             s1_blank;
   logic [23:0]      pal_q;
   logic [23:0]      rgb_q;

   assign pal_layer_ok = (int'(pal_layer) < NUM_LAYERS);

   // ---------------------------------------------------------------- blink
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         frame_cnt   <= 8'd0;
         blink_phase <= 1'b1;
      end else if (frame_start) begin
         if (frame_cnt >= 8'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= 8'd0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------- palette
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int l = 0; l < NUM_LAYERS; l++) begin
            for (int e = 0; e < DEPTH; e++) begin
               pal_mem[l][e] <= 24'h000000;
            end
         end
      end else if (pal_we && pal_layer_ok) begin
         pal_mem[pal_layer][pal_addr] <= pal_data;
      end
   end

`ifdef LAYERED_CM_READBACK_EN
   // Reads sample the array before this edge's write lands, so a same-entry
   // collision returns the old value.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pal_rdata <= 24'h000000;
      end else if (pal_re) begin
         pal_rdata <= pal_layer_ok ? pal_mem[pal_layer][pal_addr] : 24'h000000;
      end
   end
`endif

   // ---------------------------------------------------------------- stage 1
   // Walk from the lowest priority upward so the lowest-numbered opaque layer wins.
   always_comb begin
      hit     = 1'b0;
      sel     = '0;
      sel_idx = '0;
      lidx    = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         lidx = layer_index[i*IDX_W +: IDX_W];
         if (layer_active[i] && (lidx != '0) && !(BLINK_MASK[i] && !blink_phase)) begin
            hit     = 1'b1;
            sel     = LW'(i);
            sel_idx = lidx;
         end
      end
   end

   assign blank = (DrawX >= 10'd640) || (DrawY >= 10'd480);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_valid <= 1'b0;
         s1_hit   <= 1'b0;
         s1_sel   <= '0;
         s1_idx   <= '0;
         s1_blank <= 1'b0;
      end else begin
         s1_valid <= pix_valid;
         if (pix_valid) begin
            s1_hit   <= hit;
            s1_sel   <= sel;
            s1_idx   <= sel_idx;
            s1_blank <= blank;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   assign pal_q = pal_mem[s1_sel][s1_idx];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rgb_q     <= 24'h000000;
         out_layer <= OLW'(NUM_LAYERS);
         out_valid <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            if (s1_blank) begin
               rgb_q     <= 24'h000000;
               out_layer <= OLW'(NUM_LAYERS);
            end else if (!s1_hit) begin
               rgb_q     <= BG_COLOR;
               out_layer <= OLW'(NUM_LAYERS);
            end else begin
               rgb_q     <= pal_q;
               out_layer <= OLW'(s1_sel);
            end
         end
      end
   end

   assign VGA_R = rgb_q[23:16];
   assign VGA_G = rgb_q[15:8];
   assign VGA_B = rgb_q[7:0];

endmodule

// File: tb/tb_layered_color_mapper.sv
// Directed bench for layered_color_mapper: vector table plus blink, collision and reset sequences.
module tb_layered_color_mapper;

   logic        clk;
   logic        rst;
   logic        pix_valid;
   logic [9:0]  draw_x;
   logic [9:0]  draw_y;
   logic [3:0]  layer_active;
   logic [15:0] layer_index;
   logic        frame_start;
   logic        pal_we;
   logic [1:0]  pal_layer;
   logic [3:0]  pal_addr;
   logic [23:0] pal_data;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        out_valid;
   logic [2:0]  out_layer;
`ifdef LAYERED_CM_READBACK_EN
   logic        pal_re;
   logic [23:0] pal_rdata;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   layered_color_mapper dut (
      .Clk          (clk),
      .Reset        (rst),
      .pix_valid    (pix_valid),
      .DrawX        (draw_x),
      .DrawY        (draw_y),
      .layer_active (layer_active),
      .layer_index  (layer_index),
      .frame_start  (frame_start),
      .pal_we       (pal_we),
      .pal_layer    (pal_layer),
      .pal_addr     (pal_addr),
      .pal_data     (pal_data),
`ifdef LAYERED_CM_READBACK_EN
      .pal_re       (pal_re),
      .pal_rdata    (pal_rdata),
`endif
      .VGA_R        (vga_r),
      .VGA_G        (vga_g),
      .VGA_B        (vga_b),
      .out_valid    (out_valid),
      .out_layer    (out_layer)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [3:0]  act;
      logic [15:0] idx;
      logic [23:0] rgb;
      logic [2:0]  lay;
   } vec_t;

   vec_t vecs[12];

   // checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_out(input string name, input logic [23:0] rgb, input logic [2:0] lay,
                            input logic vld);
      check({name, ".rgb"},   32'({vga_r, vga_g, vga_b}), 32'(rgb));
      check({name, ".layer"}, 32'(out_layer), 32'(lay));
      check({name, ".valid"}, 32'(out_valid), 32'(vld));
   endtask

   // drivers
   task automatic pal_write(input logic [1:0] l, input logic [3:0] a, input logic [23:0] d);
      @(negedge clk);
      pal_we = 1'b1; pal_layer = l; pal_addr = a; pal_data = d;
      @(negedge clk);
      pal_we = 1'b0;
   endtask

   task automatic set_pixel(input logic [9:0] x, input logic [9:0] y, input logic [3:0] act,
                            input logic [15:0] idx);
      draw_x = x; draw_y = y; layer_active = act; layer_index = idx; pix_valid = 1'b1;
   endtask

   // One pixel in, sampled at the negedge where it has just come out.
   task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y, input logic [3:0] act,
                              input logic [15:0] idx);
      @(negedge clk);
      set_pixel(x, y, act, idx);
      @(negedge clk);
      pix_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pix_valid = 1'b0; draw_x = '0; draw_y = '0; layer_active = '0;
      layer_index = '0; frame_start = 1'b0; pal_we = 1'b0; pal_layer = '0; pal_addr = '0;
      pal_data = '0;
`ifdef LAYERED_CM_READBACK_EN
      pal_re = 1'b0;
`endif
      vecs[0]  = '{10'd100, 10'd100, 4'b1000, 16'hB000, 24'h2121FF, 3'd3};
      vecs[1]  = '{10'd5,   10'd5,   4'b0101, 16'h0205, 24'hFFFF00, 3'd0};
      vecs[2]  = '{10'd5,   10'd5,   4'b0101, 16'h0200, 24'hFFB5B5, 3'd2};
      vecs[3]  = '{10'd20,  10'd30,  4'b0000, 16'hB275, 24'h000000, 3'd4};
      vecs[4]  = '{10'd20,  10'd30,  4'b1110, 16'hB275, 24'h123456, 3'd1};
      vecs[5]  = '{10'd21,  10'd30,  4'b1111, 16'hB270, 24'h123456, 3'd1};
      vecs[6]  = '{10'd22,  10'd30,  4'b1000, 16'h1000, 24'hABCDEF, 3'd3};
      vecs[7]  = '{10'd23,  10'd30,  4'b0111, 16'hB000, 24'h000000, 3'd4};
      vecs[8]  = '{10'd24,  10'd30,  4'b0010, 16'h0030, 24'h000000, 3'd1};
      vecs[9]  = '{10'd640, 10'd10,  4'b1111, 16'hB275, 24'h000000, 3'd4};
      vecs[10] = '{10'd10,  10'd480, 4'b1111, 16'hB275, 24'h000000, 3'd4};
      vecs[11] = '{10'd639, 10'd479, 4'b1111, 16'hB275, 24'hFFFF00, 3'd0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_out("reset", 24'h000000, 3'd4, 1'b0);

      pal_write(2'd3, 4'd11, 24'h2121FF);
      pal_write(2'd0, 4'd5,  24'hFFFF00);
      pal_write(2'd2, 4'd2,  24'hFFB5B5);
      pal_write(2'd1, 4'd7,  24'h123456);
      pal_write(2'd3, 4'd1,  24'hABCDEF);

`ifdef LAYERED_CM_READBACK_EN
      @(negedge clk);
      pal_re = 1'b1; pal_layer = 2'd0; pal_addr = 4'd5;
      @(negedge clk);
      pal_re = 1'b0;
      check("readback", 32'(pal_rdata), 32'h00FFFF00);
`endif

      for (int i = 0; i < 12; i++) begin
         drive_pixel(vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].idx);
         check_out($sformatf("vec%0d", i), vecs[i].rgb, vecs[i].lay, 1'b1);
      end

      // latency: nothing new after one edge, result after two, then held
      @(negedge clk);
      set_pixel(10'd50, 10'd50, 4'b1000, 16'hB000);
      @(negedge clk);
      pix_valid = 1'b0;
      check_out("lat1", 24'hFFFF00, 3'd0, 1'b0);
      @(negedge clk);
      check_out("lat2", 24'h2121FF, 3'd3, 1'b1);
      @(negedge clk);
      check_out("hold", 24'h2121FF, 3'd3, 1'b0);

      // blink on layer 2
      for (int k = 0; k < 7; k++) pulse_frame();
      drive_pixel(10'd60, 10'd60, 4'b0100, 16'h0200);
      check_out("blink_f7", 24'hFFB5B5, 3'd2, 1'b1);
      pulse_frame();
      drive_pixel(10'd60, 10'd60, 4'b0100, 16'h0200);
      check_out("blink_f8", 24'h000000, 3'd4, 1'b1);
      drive_pixel(10'd60, 10'd60, 4'b1100, 16'hB200);
      check_out("blink_under", 24'h2121FF, 3'd3, 1'b1);
      drive_pixel(10'd60, 10'd60, 4'b0101, 16'h0205);
      check_out("blink_l0", 24'hFFFF00, 3'd0, 1'b1);
      for (int k = 0; k < 7; k++) pulse_frame();
      drive_pixel(10'd60, 10'd60, 4'b0100, 16'h0200);
      check_out("blink_f15", 24'h000000, 3'd4, 1'b1);
      // 16th frame_start coincides with a pixel: old (hidden) phase applies
      @(negedge clk);
      frame_start = 1'b1;
      set_pixel(10'd60, 10'd60, 4'b0100, 16'h0200);
      @(negedge clk);
      frame_start = 1'b0; pix_valid = 1'b0;
      @(negedge clk);
      check_out("blink_same", 24'h000000, 3'd4, 1'b1);
      drive_pixel(10'd60, 10'd60, 4'b0100, 16'h0200);
      check_out("blink_f16", 24'hFFB5B5, 3'd2, 1'b1);

      // palette write colliding with the stage-2 lookup
      @(negedge clk);
      set_pixel(10'd70, 10'd70, 4'b1000, 16'hB000);
      @(negedge clk);
      pix_valid = 1'b0;
      pal_we = 1'b1; pal_layer = 2'd3; pal_addr = 4'd11; pal_data = 24'h00FF00;
      @(negedge clk);
      pal_we = 1'b0;
      check_out("collide_old", 24'h2121FF, 3'd3, 1'b1);
      drive_pixel(10'd71, 10'd70, 4'b1000, 16'hB000);
      check_out("collide_new", 24'h00FF00, 3'd3, 1'b1);

      // reset with a pixel in flight
      @(negedge clk);
      set_pixel(10'd80, 10'd80, 4'b1000, 16'hB000);
      @(negedge clk);
      pix_valid = 1'b0;
      #2 rst = 1'b1;
      #1 check_out("rst_mid", 24'h000000, 3'd4, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_flush.valid", 32'(out_valid), 32'd0);
      drive_pixel(10'd81, 10'd80, 4'b1000, 16'hB000);
      check_out("rst_pal", 24'h000000, 3'd3, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
